// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the datapath fetch port: one request at a time, fixed-latency reply.
// Define IMEM_RESP_FLUSH_EN to add the branch-redirect flush input.
module imem_fetch_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
`ifdef IMEM_RESP_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_error,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [31:0] pend_addr;
  logic        pend_err;
  logic [31:0] mem [DEPTH_WORDS];

  logic flush_i;
  logic accept;
  logic req_err;
  logic load_ok;

`ifdef IMEM_RESP_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign load_ok   = load_en && (load_addr[1:0] == 2'b00) && (load_addr[31:2] < 30'(DEPTH_WORDS));
  assign req_ready = ((state == IDLE) || ((state == RESP) && rsp_ready)) && !flush_i;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  // Accept only happens from IDLE or from a completing RESP, so it never collides with the BUSY countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_addr <= '0;
      pend_err  <= 1'b0;
      rsp_instr <= '0;
      rsp_addr  <= '0;
      rsp_error <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept) begin
      state     <= BUSY;
      cnt       <= 3'(LATENCY - 1);
      pend_addr <= req_addr;
      pend_err  <= req_err;
    end else if ((state == RESP) && rsp_ready) begin
      state <= IDLE;
    end else if (state == BUSY) begin
      if (cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end else begin
        // Memory is sampled here, so a load landing on this same edge is not yet visible.
        state     <= RESP;
        rsp_instr <= pend_err ? NOP_INSTR : mem[pend_addr[AW+1:2]];
        rsp_addr  <= pend_addr;
        rsp_error <= pend_err;
      end
    end else if (state == 2'd3) begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok && !reset) begin
      mem[load_addr[AW+1:2]] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized self-checking bench for imem_fetch_responder against a transaction-level model.
// Flush scenarios are exercised when IMEM_RESP_FLUSH_EN is defined.
module tb_imem_fetch_responder;

  localparam int          DEPTH = 256;
  localparam int          LAT   = 3;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_s = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_error;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  int checks = 0;
  int errors = 0;

  // Reference model: program image plus the single outstanding transaction.
  logic [31:0] mem_model [DEPTH];
  bit          m_busy, m_have, m_cleared, m_err, m_last_acc;
  logic [31:0] m_addr, exp_instr, exp_addr;
  bit          exp_err;
  longint      m_edge, m_acc;

  always #5 clk = ~clk;

  imem_fetch_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef IMEM_RESP_FLUSH_EN
    .flush    (flush_s),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_addr (rsp_addr),
    .rsp_error(rsp_error),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addrBad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  task automatic doReset();
    @(negedge clk);
    req_valid = 1'b0; load_en = 1'b0; flush_s = 1'b0; rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_rsp_instr", rsp_instr, 0);
    checkOutput("reset_rsp_addr", rsp_addr, 0);
    checkOutput("reset_rsp_error", rsp_error, 0);
    @(negedge clk);
    reset = 1'b0;
    m_busy = 0; m_have = 0; m_cleared = 1;
    exp_instr = '0; exp_addr = '0; exp_err = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model across the edge.
  task automatic applyStimulus(input bit rv, input logic [31:0] ra, input bit rr,
                               input bit le, input logic [31:0] la, input logic [31:0] ld,
                               input bit fl);
    bit exp_ready, entering, release_rsp;
    @(negedge clk);
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    load_en = le; load_addr = la; load_data = ld; flush_s = fl;
    #1;
    exp_ready = (!m_busy || (m_have && rr)) && !fl;
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("rsp_valid", rsp_valid, m_have);
    if (m_have || m_cleared) begin
      checkOutput("rsp_instr", rsp_instr, exp_instr);
      checkOutput("rsp_addr", rsp_addr, exp_addr);
      checkOutput("rsp_error", rsp_error, exp_err);
    end
    m_last_acc = 0;
    if (fl) begin
      m_busy = 0; m_have = 0;
    end else begin
      entering    = m_busy && !m_have && (m_edge == m_acc + LAT);
      release_rsp = m_have && rr;
      if (entering) begin
        m_have = 1; m_cleared = 0;
        exp_addr = m_addr; exp_err = m_err;
        exp_instr = m_err ? NOP : mem_model[m_addr >> 2];
      end
      if (release_rsp) begin
        m_have = 0; m_busy = 0;
      end
      if (rv && exp_ready) begin
        m_busy = 1; m_acc = m_edge; m_addr = ra; m_err = addrBad(ra); m_last_acc = 1;
      end
    end
    if (le && !addrBad(la)) mem_model[la >> 2] = ld;
    m_edge++;
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 1, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic fetchOne(input logic [31:0] a);
    applyStimulus(1, a, 1, 0, 32'h0, 32'h0, 0);
    idleCycles(LAT + 2);
  endtask

  initial begin
    logic [31:0] prog [4];
    logic [31:0] ra, la;
    int idx, sel;
    bit fl;
    prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
    prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
    m_edge = 0; m_acc = 0; m_addr = '0; m_err = 0; m_last_acc = 0;

    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1, 1, 32'(i * 4), prog[i], 0);
    for (int i = 4; i < DEPTH; i++) applyStimulus(0, 32'h0, 1, 1, 32'(i * 4), $urandom, 0);

    fetchOne(32'h0);

    // Back-to-back stream with request held until each accept.
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      applyStimulus(1, 32'(idx * 4), 1, 0, 32'h0, 32'h0, 0);
      if (m_last_acc) idx++;
    end
    checkOutput("stream_all_accepted", 32'(idx), 32'd4);
    idleCycles(LAT + 2);

    // Backpressure then same-edge handoff to the next request.
    applyStimulus(1, 32'h8, 0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < LAT + 5; i++) applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    applyStimulus(1, 32'hC, 1, 0, 32'h0, 32'h0, 0);
    checkOutput("handoff_accept", 32'(m_last_acc), 32'd1);
    idleCycles(LAT + 2);

    // Error responses and a dropped bad load.
    fetchOne(32'h2);
    fetchOne(32'h400);
    applyStimulus(0, 32'h0, 1, 1, 32'h401, 32'hBAD0BAD0, 0);
    fetchOne(32'h0);

    // Load visible when it lands before response entry; invisible on the entry edge itself.
    applyStimulus(1, 32'h4, 1, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 32'h0, 1, 1, 32'h4, 32'hDEADBEEF, 0);
    idleCycles(LAT + 2);
    applyStimulus(1, 32'h8, 1, 0, 32'h0, 32'h0, 0);
    idleCycles(LAT - 1);
    applyStimulus(0, 32'h0, 1, 1, 32'h8, 32'h12345678, 0);
    idleCycles(3);
    fetchOne(32'h8);

    // Reset while a request is outstanding.
    applyStimulus(1, 32'hC, 1, 0, 32'h0, 32'h0, 0);
    doReset();
    idleCycles(LAT + 3);

`ifdef IMEM_RESP_FLUSH_EN
    applyStimulus(1, 32'h0, 1, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 32'h0, 1);
    idleCycles(LAT + 2);
    applyStimulus(1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
    idleCycles(0);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    applyStimulus(1, 32'h8, 1, 0, 32'h0, 32'h0, 1);
    idleCycles(LAT + 2);
`endif

    // Randomized traffic with mixed good/bad addresses, loads and backpressure.
    for (int c = 0; c < 3000; c++) begin
      sel = $urandom % 8;
      ra = (sel == 0) ? (($urandom % 1024) | 32'h1) : (sel == 1) ? (32'h400 + ($urandom % 4096)) : 32'(($urandom % DEPTH) * 4);
      sel = $urandom % 8;
      la = (sel == 0) ? (($urandom % 1024) | 32'h2) : (sel == 1) ? (32'h400 + ($urandom % 64) * 4) : 32'(($urandom % DEPTH) * 4);
      fl = 0;
`ifdef IMEM_RESP_FLUSH_EN
      fl = ($urandom % 20 == 0);
`endif
      applyStimulus(($urandom % 3) != 0, ra, ($urandom % 4) != 0, ($urandom % 4) == 0, la, $urandom, fl);
      if (c % 1000 == 999) doReset();
    end
    idleCycles(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
